multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, is the wait-state cycle limit and applies only when MCTRL_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ifu_req_valid  output  1  fetch request; ifu_req_ready  input  1  fetch request accepted.
REQ-005 ifu_rsp_valid  input  1  instruction returned; ifu_rsp_err  input  1  fetch access fault, qualified by ifu_rsp_valid.
REQ-006 lsu_req_valid  output  1  data request; lsu_req_ready  input  1  data request accepted.
REQ-007 lsu_rsp_valid  input  1  data returned; lsu_rsp_err  input  1  data access fault, qualified by lsu_rsp_valid.
REQ-008 dec_mem_rd, dec_mem_wr, dec_rf_we, dec_halt  input  1 each  decoder flags for the latched instruction.
REQ-009 dec_pc_sel  input  2  decoder next-PC select: 00 adder, 01 mtvec, 11 mepc.
REQ-010 inst_latch  output  1  instruction-register load enable.
REQ-011 pc_we  output  1  PC register update enable; pc_sel  output  2  select forwarded to the PC register.
REQ-012 rf_we  output  1  register-file write enable; trap_take  output  1  trap commit strobe; trap_cause  output  4  mcause code.
REQ-013 halted  output  1  core stopped.

Function
REQ-014 States SHALL be FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB and HALT, one-hot or encoded.
REQ-015 FETCH_REQ: ifu_req_valid=1; go to FETCH_WAIT in the cycle ifu_req_ready=1; otherwise hold with valid asserted.
REQ-016 FETCH_WAIT: on ifu_rsp_valid&~ifu_rsp_err, pulse inst_latch and go to EXEC; on ifu_rsp_valid&ifu_rsp_err, set the pending trap with cause 1 and go to WB.
REQ-017 EXEC, one cycle: dec_halt gives HALT; dec_mem_rd&dec_mem_wr gives a pending trap with cause 2, then WB; dec_mem_rd or dec_mem_wr alone gives MEM_REQ; otherwise WB.
REQ-018 MEM_REQ: lsu_req_valid=1 until lsu_req_ready, then MEM_WAIT; the rd/wr kind is captured on entry.
REQ-019 MEM_WAIT: on lsu_rsp_valid go to WB; if lsu_rsp_err also set, the pending trap cause is 5 for a load and 7 for a store.
REQ-020 WB, one cycle: pc_we=1; pc_sel = pending trap ? 01 : dec_pc_sel; rf_we = dec_rf_we & ~pending; trap_take = pending; then FETCH_REQ and clear pending.
REQ-021 HALT is absorbing until rst: halted=1, all request, strobe and enable outputs 0.
REQ-022 Outside WB, pc_we, rf_we and trap_take SHALL be 0, and pc_sel SHALL be 00.
REQ-023 trap_cause SHALL hold the pending code from capture through WB, and 0 otherwise.
REQ-024 rsp_valid inputs in any non-wait state SHALL be ignored, with no state change.
REQ-025 A response in the same cycle the request handshake completes is not accepted; it is sampled from the next cycle.
REQ-026 Minimum latency with zero-wait memory SHALL be 4 cycles for a non-memory instruction and 6 cycles for a load or store, counted from FETCH_REQ entry to the WB cycle inclusive.

Reset
REQ-027 rst SHALL force FETCH_REQ, clear the pending trap and cause, clear the timeout counter, and drive every output 0.
REQ-028 rst asserted mid-handshake or in HALT SHALL abandon the transaction; a response arriving after reset is ignored per REQ-024.

Configuration
REQ-029 With MCTRL_TIMEOUT_EN defined, a counter SHALL clear on entry to FETCH_WAIT or MEM_WAIT and increment each wait cycle without a response.
REQ-030 When that counter reaches TIMEOUT, the block SHALL treat the wait as an erroring response: cause 1 in FETCH_WAIT, 5 or 7 in MEM_WAIT.
REQ-031 A response arriving in the same cycle the counter reaches TIMEOUT SHALL take priority over the timeout.
REQ-032 Without MCTRL_TIMEOUT_EN, the wait states SHALL wait indefinitely and the counter logic SHALL be absent.

Structure
REQ-033 Package mctrl_pkg SHALL hold the state enum, the cause constants (IFU_FAULT=1, ILLEGAL=2, LD_FAULT=5, ST_FAULT=7) and the pc_sel constants.
REQ-034 Sub-module mctrl_timeout SHALL implement the counter, with inputs clr and en and output expired; it is instantiated only under MCTRL_TIMEOUT_EN.

Verification
REQ-035 ALU instruction with ready and rsp tied high -> states FETCH_REQ, FETCH_WAIT, EXEC, WB; pc_we pulses once every 4 cycles; rf_we=1 in WB.
REQ-036 Load with lsu_req_ready delayed 3 cycles -> lsu_req_valid held for 4 cycles; WB occurs 9 cycles after fetch start.
REQ-037 Fetch with ifu_rsp_err=1 -> no inst_latch; WB has pc_sel=01, trap_take=1, trap_cause=1, rf_we=0.
REQ-038 EXEC with dec_mem_rd=dec_mem_wr=1 -> no lsu_req_valid; WB has trap_cause=2.
REQ-039 dec_halt=1 -> halted=1 stays asserted for 20 cycles with pc_we=0; rst then restarts FETCH_REQ.
REQ-040 MCTRL_TIMEOUT_EN with TIMEOUT=8 and a store never answered -> trap_take with cause 7 occurs; a response in the expiry cycle gives no trap.

Source files
------------

// File: rtl/mctrl_pkg.sv
// Shared types and constants for the multicycle core controller.
// The package is the same in every build; MCTRL_TIMEOUT_EN only affects the top.
package mctrl_pkg;

   typedef enum logic [2:0] {
      FETCH_REQ  = 3'd0,
      FETCH_WAIT = 3'd1,
      EXEC       = 3'd2,
      MEM_REQ    = 3'd3,
      MEM_WAIT   = 3'd4,
      WB         = 3'd5,
      HALT       = 3'd6
   } state_e;

   // Values driven onto pc_sel toward the PC register.
   typedef enum logic [1:0] {
      PC_SEL_ADDER = 2'b00,
      PC_SEL_MTVEC = 2'b01,
      PC_SEL_MEPC  = 2'b11
   } pc_sel_e;

   localparam logic [3:0] CAUSE_NONE = 4'd0;
   localparam logic [3:0] IFU_FAULT  = 4'd1;
   localparam logic [3:0] ILLEGAL    = 4'd2;
   localparam logic [3:0] LD_FAULT   = 4'd5;
   localparam logic [3:0] ST_FAULT   = 4'd7;

   function automatic logic [3:0] memFaultCause(input logic isStore);
      return isStore ? ST_FAULT : LD_FAULT;
   endfunction

endpackage

// File: rtl/mctrl_timeout.sv
// Wait-state watchdog counter for multicycle_ctrl.
// Only compiled when MCTRL_TIMEOUT_EN is defined, so the default build carries no counter.
`ifdef MCTRL_TIMEOUT_EN
module mctrl_timeout #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   // The count saturates at the limit so a held expiry never wraps back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == Limit);

endmodule
`endif

// File: rtl/multicycle_ctrl.sv
// Multicycle core sequencer: fetch, execute, optional memory access, writeback/trap commit.
// Define MCTRL_TIMEOUT_EN to bound the fetch/memory wait states by TIMEOUT cycles.
module multicycle_ctrl
   import mctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   output logic       ifu_req_valid,
   input  logic       ifu_req_ready,
   input  logic       ifu_rsp_valid,
   input  logic       ifu_rsp_err,
   output logic       lsu_req_valid,
   input  logic       lsu_req_ready,
   input  logic       lsu_rsp_valid,
   input  logic       lsu_rsp_err,
   input  logic       dec_mem_rd,
   input  logic       dec_mem_wr,
   input  logic       dec_rf_we,
   input  logic       dec_halt,
   input  logic [1:0] dec_pc_sel,
   output logic       inst_latch,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       rf_we,
   output logic       trap_take,
   output logic [3:0] trap_cause,
   output logic       halted
);

   state_e     state_q, state_d;
   logic       pend_q, pend_d;
   logic [3:0] cause_q, cause_d;
   logic       isStore_q, isStore_d;

   logic       ifuReqValid, lsuReqValid, instLatch, pcWe, rfWe, trapTake, haltedC;
   logic [1:0] pcSel;

`ifdef MCTRL_TIMEOUT_EN
   logic tmoClr, tmoEn, tmoExpired;

   mctrl_timeout #(.TIMEOUT(TIMEOUT)) uTimeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmoClr),
      .en      (tmoEn),
      .expired (tmoExpired)
   );
`else
   // TIMEOUT has no effect without the counter; this empty block just consumes it.
   if (TIMEOUT == 0) begin : gTimeoutUnused
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH_REQ;
         pend_q    <= 1'b0;
         cause_q   <= CAUSE_NONE;
         isStore_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         cause_q   <= cause_d;
         isStore_q <= isStore_d;
      end
   end

   // Responses are only looked at in the wait states, so one arriving together with
   // the request handshake is seen no earlier than the first wait cycle.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      cause_d     = cause_q;
      isStore_d   = isStore_q;
      ifuReqValid = 1'b0;
      lsuReqValid = 1'b0;
      instLatch   = 1'b0;
      pcWe        = 1'b0;
      pcSel       = PC_SEL_ADDER;
      rfWe        = 1'b0;
      trapTake    = 1'b0;
      haltedC     = 1'b0;
`ifdef MCTRL_TIMEOUT_EN
      tmoClr      = 1'b0;
      tmoEn       = 1'b0;
`endif

      case (state_q)
         FETCH_REQ: begin
            ifuReqValid = 1'b1;
            if (ifu_req_ready) begin
               state_d = FETCH_WAIT;
`ifdef MCTRL_TIMEOUT_EN
               tmoClr  = 1'b1;
`endif
            end
         end

         FETCH_WAIT: begin
            if (ifu_rsp_valid) begin
               if (ifu_rsp_err) begin
                  pend_d  = 1'b1;
                  cause_d = IFU_FAULT;
                  state_d = WB;
               end else begin
                  instLatch = 1'b1;
                  state_d   = EXEC;
               end
            end
`ifdef MCTRL_TIMEOUT_EN
            else if (tmoExpired) begin
               pend_d  = 1'b1;
               cause_d = IFU_FAULT;
               state_d = WB;
            end else begin
               tmoEn = 1'b1;
            end
`endif
         end

         EXEC: begin
            if (dec_halt) begin
               state_d = HALT;
            end else if (dec_mem_rd && dec_mem_wr) begin
               pend_d  = 1'b1;
               cause_d = ILLEGAL;
               state_d = WB;
            end else if (dec_mem_rd || dec_mem_wr) begin
               isStore_d = dec_mem_wr;
               state_d   = MEM_REQ;
            end else begin
               state_d = WB;
            end
         end

         MEM_REQ: begin
            lsuReqValid = 1'b1;
            if (lsu_req_ready) begin
               state_d = MEM_WAIT;
`ifdef MCTRL_TIMEOUT_EN
               tmoClr  = 1'b1;
`endif
            end
         end

         MEM_WAIT: begin
            if (lsu_rsp_valid) begin
               if (lsu_rsp_err) begin
                  pend_d  = 1'b1;
                  cause_d = memFaultCause(isStore_q);
               end
               state_d = WB;
            end
`ifdef MCTRL_TIMEOUT_EN
            else if (tmoExpired) begin
               pend_d  = 1'b1;
               cause_d = memFaultCause(isStore_q);
               state_d = WB;
            end else begin
               tmoEn = 1'b1;
            end
`endif
         end

         WB: begin
            pcWe     = 1'b1;
            pcSel    = pend_q ? PC_SEL_MTVEC : dec_pc_sel;
            rfWe     = dec_rf_we & ~pend_q;
            trapTake = pend_q;
            pend_d   = 1'b0;
            cause_d  = CAUSE_NONE;
            state_d  = FETCH_REQ;
         end

         HALT: begin
            haltedC = 1'b1;
         end

         default: begin
            state_d = FETCH_REQ;
         end
      endcase
   end

   // Outputs are forced low for the whole reset cycle, whatever state is still held.
   assign ifu_req_valid = ifuReqValid & ~rst;
   assign lsu_req_valid = lsuReqValid & ~rst;
   assign inst_latch    = instLatch & ~rst;
   assign pc_we         = pcWe & ~rst;
   assign pc_sel        = rst ? PC_SEL_ADDER : pcSel;
   assign rf_we         = rfWe & ~rst;
   assign trap_take     = trapTake & ~rst;
   assign trap_cause    = rst ? CAUSE_NONE : cause_q;
   assign halted        = haltedC & ~rst;

endmodule
